instr_fetch_unit: RTL and testbench

//   Supplies 10-bit instruction words (iiiidddddd) to the single-cycle control unit. Owns PC,

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_wdog.sv | 36 +++
 rtl/instr_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch unit and the control unit.
//   - default PC / instruction widths
//   - instruction field layout (opcode [9:6], operand [5:0]) and opcode constants
//   - fetch_state_t: fetch sequencer states
package cpu_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 10;
    localparam int OPC_W       = 4;
    localparam int OPND_W      = 6;

    localparam logic [OPC_W-1:0] OPC_JMP = 4'b1001;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_wdog.sv
// fetch_wdog: watchdog for the fetch WAIT state.
//   clk, reset_n : clock / async active-low reset
//   clr          : synchronous clear (wins over en)
//   en           : count one more idle wait cycle
//   tc           : terminal-count pulse, high in the cycle en=1 with count==TIMEOUT-1
module fetch_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && cnt_q != TC_VAL)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign tc = en && !clr && (cnt_q == TC_VAL);

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, issues one program-memory read per
// instruction, holds the fetched word for the decoder and applies jumps.
//   clk, reset_n        : clock / async active-low reset
//   run, halt_req       : start/resume level, stop-after-issue request
//   stall               : hold the current instruction in ISSUE
//   load_PC, pc_value   : jump request from the decoder (ISSUE only)
//   imem_req/addr       : one-cycle read request, address = pc
//   imem_rvalid/rdata   : read response (accepted only in WAIT)
//   instruction         : registered word to the decoder
//   instr_valid, pc     : word is current / its address
//   halted, fault       : in HALT / sticky fetch timeout
// Optional build macro FETCH_BREAKPOINT_EN adds bkpt_addr, bkpt_en, bkpt_hit:
// a FETCH at the breakpoint address goes to HALT without a request; the
// following resume fetches that address once without re-checking.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic               halt_req,
    input  logic               stall,
    input  logic               load_PC,
    input  logic [PC_W-1:0]    pc_value,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic               fault
`ifdef FETCH_BREAKPOINT_EN
    ,
    input  logic [PC_W-1:0]    bkpt_addr,
    input  logic               bkpt_en,
    output logic               bkpt_hit
`endif
);

    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               iv_q, iv_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;
    logic               wd_clr, wd_en, wd_tc;
    logic               bkpt_div;

    fetch_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .tc      (wd_tc)
    );

`ifdef FETCH_BREAKPOINT_EN
    logic bkpt_hit_q, bkpt_hit_d;
    logic bkpt_skip_q, bkpt_skip_d;   // one-shot bypass after a breakpoint halt

    assign bkpt_div = (state_q == FETCH) && bkpt_en && (pc_q == bkpt_addr) && !bkpt_skip_q;

    always_comb begin
        bkpt_hit_d  = bkpt_hit_q;
        bkpt_skip_d = bkpt_skip_q;
        if (state_q == FETCH) begin
            bkpt_hit_d  = bkpt_div;
            bkpt_skip_d = bkpt_div;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bkpt_hit_q  <= 1'b0;
            bkpt_skip_q <= 1'b0;
        end else begin
            bkpt_hit_q  <= bkpt_hit_d;
            bkpt_skip_q <= bkpt_skip_d;
        end
    end

    assign bkpt_hit = bkpt_hit_q;
`else
    assign bkpt_div = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        fault_d  = fault_q;
        imem_req = 1'b0;
        wd_clr   = 1'b0;
        wd_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                wd_clr = 1'b1;
                if (bkpt_div) begin
                    state_d = HALT;
                end else begin
                    imem_req = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end else begin
                    wd_en = 1'b1;
                    if (wd_tc) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end
                end
            end
            ISSUE: begin
                // stall freezes everything, including a pending jump
                if (!stall) begin
                    pc_d    = load_PC ? pc_value : pc_q + 1'b1;
                    state_d = halt_req ? HALT : FETCH;
                end
            end
            HALT: begin
                if (run && !halt_req && !fault_q) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
        // status flags registered from the next state so they track it exactly
        iv_d     = (state_d == ISSUE);
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            iv_q     <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            iv_q     <= iv_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_valid = iv_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: the driver plays program memory and decoder,
// walking fetch transactions (request, response latency, stalls, jump, halt)
// and publishing the outputs each cycle must show; one negedge process
// compares every output against those expectations.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam int PW = 8;
    localparam int IW = 10;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          run = 1'b0, halt_req = 1'b0, stall = 1'b0, load_PC = 1'b0;
    logic [PW-1:0] pc_value = '0;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_rvalid = 1'b0;
    logic [IW-1:0] imem_rdata = '0;
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic [PW-1:0] pc;
    logic          halted, fault;

    always #5 clk = ~clk;

    instr_fetch_unit #(.PC_W(PW), .INSTR_W(IW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .halt_req    (halt_req),
        .stall       (stall),
        .load_PC     (load_PC),
        .pc_value    (pc_value),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted),
        .fault       (fault)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model of the architectural state
    logic [PW-1:0] m_pc = '0;
    logic [IW-1:0] m_instr = '0;
    logic          m_fault = 1'b0;

    // expectations for the current cycle
    bit            e_on = 0;
    logic          e_req, e_iv, e_halted, e_fault;
    logic [PW-1:0] e_pc;
    logic [IW-1:0] e_instr;

    // observations used by literal checks
    logic [PW-1:0] req_a[$];
    int            req_c[$];
    int            fault_cyc = -1;
    logic [IW-1:0] last_iv_instr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (e_on) begin
            chk("imem_req",    imem_req,    e_req);
            chk("imem_addr",   imem_addr,   e_pc);
            chk("pc",          pc,          e_pc);
            chk("instr_valid", instr_valid, e_iv);
            chk("instruction", instruction, e_instr);
            chk("halted",      halted,      e_halted);
            chk("fault",       fault,       e_fault);
        end
        if (imem_req === 1'b1) begin
            req_a.push_back(imem_addr);
            req_c.push_back(cyc);
        end
        if (fault === 1'b1 && fault_cyc < 0) fault_cyc = cyc;
        if (instr_valid === 1'b1) last_iv_instr = instruction;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic req, input logic iv, input logic h);
        e_req = req; e_iv = iv; e_halted = h;
        e_pc = m_pc; e_instr = m_instr; e_fault = m_fault;
        e_on = 1;
    endtask

    // inputs that must not matter in the current state
    task automatic noise();
        run      = 1'($urandom_range(0, 1));
        halt_req = 1'($urandom_range(0, 1));
        stall    = 1'($urandom_range(0, 1));
        load_PC  = 1'($urandom_range(0, 1));
        pc_value = PW'($urandom);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run = 0; halt_req = 0; stall = 0; load_PC = 0; imem_rvalid = 0;
        m_pc = '0; m_instr = '0; m_fault = 1'b0;
        set_exp(0, 0, 0);
        fault_cyc = -1;
        #1;
        chk("rst_req",    imem_req,    0);
        chk("rst_pc",     pc,          0);
        chk("rst_instr",  instruction, 0);
        chk("rst_iv",     instr_valid, 0);
        chk("rst_halted", halted,      0);
        chk("rst_fault",  fault,       0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // one IDLE cycle with run=1
    task automatic do_idle();
        set_exp(0, 0, 0);
        noise(); run = 1'b1; imem_rvalid = 1'b0;
        step();
    endtask

    // called in a FETCH cycle; lat > TO means memory never answers
    task automatic do_fetch(input int lat, input logic [IW-1:0] data, input int nstall,
                            input bit jmp, input logic [PW-1:0] tgt, input bit hreq);
        set_exp(1, 0, 0);
        noise();
        imem_rvalid = 1'($urandom_range(0, 1));
        imem_rdata  = IW'($urandom);
        step();
        if (lat > TO) begin
            for (int i = 1; i <= TO; i++) begin
                set_exp(0, 0, 0);
                noise(); imem_rvalid = 1'b0;
                step();
            end
            m_fault = 1'b1;
            return;
        end
        for (int i = 1; i <= lat; i++) begin
            set_exp(0, 0, 0);
            noise();
            imem_rvalid = (i == lat);
            imem_rdata  = (i == lat) ? data : IW'($urandom);
            step();
        end
        m_instr = data;
        for (int s = 0; s < nstall; s++) begin
            set_exp(0, 1, 0);
            noise(); stall = 1'b1; load_PC = 1'b1;
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = IW'($urandom);
            step();
        end
        set_exp(0, 1, 0);
        run = 1'($urandom_range(0, 1));
        stall = 1'b0; load_PC = jmp; pc_value = tgt; halt_req = hreq;
        imem_rvalid = 1'($urandom_range(0, 1));
        step();
        m_pc = jmp ? tgt : PW'(m_pc + 1);
    endtask

    // n cycles that must stay in HALT, then resume (unless faulted)
    task automatic do_halt(input int n, input bit resume);
        for (int i = 0; i < n; i++) begin
            set_exp(0, 0, 1);
            noise(); imem_rvalid = 1'($urandom_range(0, 1));
            if (m_fault) begin
                run = 1'b1; halt_req = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                run = 1'b0;
            end else begin
                run = 1'b1; halt_req = 1'b1;
            end
            step();
        end
        if (resume && !m_fault) begin
            set_exp(0, 0, 1);
            noise(); run = 1'b1; halt_req = 1'b0; imem_rvalid = 1'b0;
            step();
        end
    endtask

    initial begin
        logic [IW-1:0] rd;
        #2;
        do_reset();

        // three sequential fetches at 1-cycle latency
        req_a.delete(); req_c.delete();
        do_idle();
        do_fetch(1, 10'h001, 0, 0, '0, 0);
        chk("t2_instr0", last_iv_instr, 10'h001);
        do_fetch(1, 10'h002, 0, 0, '0, 0);
        do_fetch(1, 10'h003, 0, 0, '0, 0);
        chk("t2_addr0", req_a[0], 0);
        chk("t2_addr1", req_a[1], 1);
        chk("t2_addr2", req_a[2], 2);
        chk("t2_gap01", req_c[1] - req_c[0], 3);
        chk("t2_gap12", req_c[2] - req_c[1], 3);
        chk("t2_instr2", last_iv_instr, 10'h003);

        // JMP 5
        rd = {OPC_JMP, 6'd5};
        do_fetch(1, rd, 0, 1, 8'd5, 0);
        do_fetch(2, IW'($urandom), 0, 0, '0, 0);
        chk("t3_jmp_addr", req_a[$], 5);

        // wrap 255 -> 0
        do_fetch(1, IW'($urandom), 0, 1, 8'hFF, 0);
        do_fetch(1, IW'($urandom), 0, 0, '0, 0);
        chk("t4_addr255", req_a[$], 8'hFF);
        do_fetch(1, IW'($urandom), 0, 0, '0, 0);
        chk("t4_wrap", req_a[$], 0);

        // 4-cycle stall with load_PC=1 held, released without jump
        do_fetch(3, IW'($urandom), 4, 0, '0, 0);
        do_fetch(1, IW'($urandom), 0, 0, '0, 0);
        chk("t6_stall_next", req_a[$], 2);

        // halt after issue together with a jump, then resume
        do_fetch(1, IW'($urandom), 1, 1, 8'h40, 1);
        do_halt(3, 1);
        do_fetch(1, IW'($urandom), 0, 0, '0, 0);
        chk("halt_jmp_addr", req_a[$], 8'h40);

        // randomized transactions
        for (int t = 0; t < 60; t++) begin
            bit h;
            h = ($urandom_range(0, 7) == 0);
            do_fetch($urandom_range(1, 4), IW'($urandom), ($urandom_range(0, 3) == 3) ? $urandom_range(1, 3) : 0,
                     ($urandom_range(0, 3) == 0), PW'($urandom), h);
            if (h) do_halt($urandom_range(0, 3), 1);
        end

        // reset in the middle of WAIT; the late response must be ignored
        set_exp(1, 0, 0); noise(); imem_rvalid = 1'b0; step();
        set_exp(0, 0, 0); noise(); imem_rvalid = 1'b0; step();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_exp(0, 0, 0);
            run = 1'b0; imem_rvalid = 1'b1; imem_rdata = IW'($urandom);
            step();
        end
        chk("t1_no_issue", last_iv_instr !== 10'bx, 1);
        imem_rvalid = 1'b0;

        // watchdog timeout
        req_a.delete(); req_c.delete();
        do_idle();
        do_fetch(99, '0, 0, 0, '0, 0);
        do_halt(4, 0);
        chk("t5_fault_cycles", fault_cyc - req_c[0], TO + 1);
        chk("t5_fault_pc", req_a[0], 0);

        do_reset();
        do_idle();
        do_fetch(1, 10'h3AA, 0, 0, '0, 0);
        chk("post_fault_instr", last_iv_instr, 10'h3AA);

        e_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
